video_stream_scheduler: RTL
===========================

Name: video_stream_scheduler

Overview:
- Frame-aware scheduler that shares the single video output stream between the camera sink and the SD-card sink.
- Switches the selected source only on frame boundaries (startofpacket/endofpacket).
- Implements pause-at-end-of-frame, counts completed frames, raises a per-frame interrupt.
- Sits between the two Avalon-ST sink interfaces and the video effects/source stage, driven by Avalon-MM control bits.

Parameters:
DATA_W, 16, stream data width (RGB565)
COUNT_W, 16, width of completed-frame counter
DISCARD_IDLE, 1, 1: non-active sink held ready and beats dropped; 0: non-active sink backpressured (ready=0)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
sel_req  in  1  requested source: 0 camera, 1 SD card
pause_req  in  1  request pause at next frame end
irq_enable  in  1  enable frame-end interrupt
irq_ack  in  1  clear irq (single-cycle pulse)
err_clear  in  1  clear frame_error
cam_valid, cam_startofpacket, cam_endofpacket  in  1 each  camera sink
cam_data  in  DATA_W  camera pixels
cam_ready  out  1  to camera source
sd_valid, sd_startofpacket, sd_endofpacket  in  1 each  SD sink
sd_data  in  DATA_W  SD pixels
sd_ready  out  1  to SD source
out_ready  in  1  downstream ready
out_valid, out_startofpacket, out_endofpacket  out  1 each  output stream
out_data  out  DATA_W  output pixels
active_sel  out  1  source currently scheduled
paused  out  1  high while in PAUSED
frame_count  out  COUNT_W  completed frames, wraps
irq  out  1  sticky frame-end interrupt
frame_error  out  1  sticky: unexpected startofpacket mid-frame

Behaviour:
- Reset (async): state=SYNC; active_sel=0; out_valid/sop/eop=0; out_data=0; frame_count=0; irq=0; frame_error=0.
- Output stage: one registered beat.
  - can_load = ~out_valid | out_ready.
  - A beat is accepted from the active sink when its valid & ready are both high.
  - Latency is 1 cycle from acceptance to out_valid.
  - When out_valid=1 and out_ready=0, all out_* hold stable.
  - out_valid clears when a beat is consumed and no new beat is forwarded.
- Active sink ready: can_load in SYNC and STREAM. In PAUSED: 1 if DISCARD_IDLE, else 0.
- Inactive sink ready: DISCARD_IDLE ? 1 : 0. Its beats are never forwarded.
- States:
  - SYNC: accepted beats without sop are dropped (not forwarded, not counted).
    - Accepted beat with sop: forwarded, go to STREAM.
    - If that beat also has eop, the frame-end actions run this cycle and the next state follows the frame-end rule.
    - pause_req=1 and no sop accepted this cycle: go to PAUSED. If a sop is accepted in the same cycle, the sop wins and the pause applies at that frame's end.
  - STREAM: every accepted beat is forwarded.
    - Accepted sop without eop: forwarded, frame_error<=1, stay in STREAM.
    - Accepted eop: frame-end actions run. Next state is PAUSED if pause_req=1, else SYNC.
  - PAUSED: nothing forwarded. When pause_req=0: go to SYNC, active_sel<=sel_req.
- Frame-end actions:
  - frame_count<=frame_count+1, wrapping modulo 2^COUNT_W.
  - If irq_enable: irq<=1.
  - If the next state is SYNC: active_sel<=sel_req.
- active_sel changes only at the frame-end/PAUSED-exit points above. sel_req changes mid-frame have no effect until the frame ends.
- irq: set wins over irq_ack in the same cycle; otherwise irq_ack clears it. irq_enable=0 blocks new sets but does not clear a pending irq.
- frame_error: set wins over err_clear in the same cycle.
- Reset mid-frame: all state returns to reset values immediately; the partial frame is abandoned with no eop emitted.

Test Plan:
- Camera frame: sop beat 0x1111, 4 middle beats, eop beat 0x5555, out_ready=1, irq_enable=1 -> same 6 beats on out 1 cycle later, sop/eop aligned; frame_count=1; irq=1 the cycle after the eop is accepted.
- sel_req 0->1 asserted on beat 3 of a camera frame -> remaining camera beats forwarded; active_sel becomes 1 only after the camera eop; SD beats before the next SD sop are dropped; the first forwarded SD beat carries sop.
- out_ready low for 3 cycles mid-frame -> out_data/out_valid held; cam_ready=0 for those cycles; no beat lost or duplicated (compare sequence 0x0001..0x0010).
- pause_req=1 mid-frame -> frame completes, paused=1 next cycle; with DISCARD_IDLE=1 cam_ready=1 and out_valid=0 while paused; pause_req=0 -> SYNC; output resumes at the next camera sop.
- Mid-frame sop injected in STREAM -> beat forwarded, frame_error=1; err_clear with no new error -> 0. irq_ack in the same cycle as a frame-end -> irq stays 1.
- Assert reset mid-frame, then 2^16 single-beat frames (sop+eop) -> after reset all outputs are 0 and state is SYNC; frame_count wraps to 0; out_sop=out_eop=1 on each beat.

Source files
------------

// File: rtl/video_stream_scheduler.sv
// Frame-aware scheduler sharing one Avalon-ST video output between the camera and SD-card sinks.
// Source changes happen only at frame boundaries; supports pause-at-frame-end, frame counting and a frame IRQ.
module video_stream_scheduler #(
  parameter int DATA_W       = 16,
  parameter int COUNT_W      = 16,
  parameter bit DISCARD_IDLE = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sel_req,
  input  logic               pause_req,
  input  logic               irq_enable,
  input  logic               irq_ack,
  input  logic               err_clear,
  input  logic               cam_valid,
  input  logic               cam_startofpacket,
  input  logic               cam_endofpacket,
  input  logic [DATA_W-1:0]  cam_data,
  output logic               cam_ready,
  input  logic               sd_valid,
  input  logic               sd_startofpacket,
  input  logic               sd_endofpacket,
  input  logic [DATA_W-1:0]  sd_data,
  output logic               sd_ready,
  input  logic               out_ready,
  output logic               out_valid,
  output logic               out_startofpacket,
  output logic               out_endofpacket,
  output logic [DATA_W-1:0]  out_data,
  output logic               active_sel,
  output logic               paused,
  output logic [COUNT_W-1:0] frame_count,
  output logic               irq,
  output logic               frame_error
);

  localparam logic [1:0] SYNC   = 2'd0;
  localparam logic [1:0] STREAM = 2'd1;
  localparam logic [1:0] PAUSED = 2'd2;

  logic [1:0]        state, state_nxt;
  logic              sel_nxt;
  logic              vld_p1, sop_p1, eop_p1;
  logic [DATA_W-1:0] data_p1;

  logic              act_valid, act_sop, act_eop, act_ready;
  logic [DATA_W-1:0] act_data;
  logic              can_load, accept, fwd, frame_end, err_set;
  logic [1:0]        end_state;

  assign act_valid = active_sel ? sd_valid         : cam_valid;
  assign act_sop   = active_sel ? sd_startofpacket : cam_startofpacket;
  assign act_eop   = active_sel ? sd_endofpacket   : cam_endofpacket;
  assign act_data  = active_sel ? sd_data          : cam_data;

  assign can_load  = ~vld_p1 | out_ready;
  assign act_ready = (state == PAUSED) ? DISCARD_IDLE : can_load;
  assign cam_ready = active_sel ? DISCARD_IDLE : act_ready;
  assign sd_ready  = active_sel ? act_ready : DISCARD_IDLE;

  // In SYNC only a start-of-packet beat may open a frame; PAUSED swallows everything.
  assign accept    = act_valid & act_ready;
  assign fwd       = accept & ((state == STREAM) | ((state == SYNC) & act_sop));
  assign frame_end = fwd & act_eop;
  assign err_set   = (state == STREAM) & accept & act_sop & ~act_eop;
  assign end_state = pause_req ? PAUSED : SYNC;

  always_comb begin
    state_nxt = state;
    sel_nxt   = active_sel;
    case (state)
      SYNC: begin
        if (fwd)            state_nxt = act_eop ? end_state : STREAM;
        else if (pause_req) state_nxt = PAUSED;
      end
      STREAM: if (frame_end) state_nxt = end_state;
      PAUSED: if (!pause_req) state_nxt = SYNC;
      default: state_nxt = SYNC;
    endcase
    if ((frame_end && !pause_req) || (state == PAUSED && !pause_req)) sel_nxt = sel_req;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= SYNC;
      active_sel  <= 1'b0;
      frame_count <= '0;
      irq         <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      state      <= state_nxt;
      active_sel <= sel_nxt;
      if (frame_end) frame_count <= frame_count + COUNT_W'(1);
      if (frame_end && irq_enable) irq <= 1'b1;
      else if (irq_ack)            irq <= 1'b0;
      if (err_set)        frame_error <= 1'b1;
      else if (err_clear) frame_error <= 1'b0;
    end
  end

  // ---- stage p1: registered output beat ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1  <= 1'b0;
      sop_p1  <= 1'b0;
      eop_p1  <= 1'b0;
      data_p1 <= '0;
    end else if (can_load) begin
      vld_p1 <= fwd;
      if (fwd) begin
        sop_p1  <= act_sop;
        eop_p1  <= act_eop;
        data_p1 <= act_data;
      end
    end
  end

  assign out_valid         = vld_p1;
  assign out_startofpacket = sop_p1;
  assign out_endofpacket   = eop_p1;
  assign out_data          = data_p1;
  assign paused            = (state == PAUSED);

endmodule
